// File: rtl/sysbus_pkg.sv
// Shared types for the sysbus request arbiter / response router.
// Outstanding-table entries are sized for up to 16 ports and 16-bit tags.
package sysbus_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_TAG_WIDTH  = 13;
    localparam int TAG_WRITE_BIT  = DEF_TAG_WIDTH - 1;

    localparam int ENTRY_TAG_W  = 16;
    localparam int ENTRY_PORT_W = 4;
    localparam int ENTRY_BEAT_W = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    typedef struct packed {
        logic                    valid;
        logic [ENTRY_TAG_W-1:0]  tag;
        logic [ENTRY_PORT_W-1:0] port;
        logic [ENTRY_BEAT_W-1:0] beats;
    } entry_t;

    function automatic logic tag_is_write(
        input logic [ENTRY_TAG_W-1:0] tag,
        input int                     wbit
    );
        return tag[wbit];
    endfunction

endpackage

// File: rtl/sysbus_arbiter_if.sv
// Client-side bundle (one lane per port) and the single sysbus channel.
// master drives requests on each bundle; slave answers them.
interface sysbus_port_if
    import sysbus_pkg::*;
#(
    parameter int NPORTS     = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH
);
    logic [NPORTS-1:0][DATA_WIDTH-1:0] port_req;
    logic [NPORTS-1:0][TAG_WIDTH-1:0]  port_reqtag;
    logic [NPORTS-1:0]                 port_reqcyc;
    logic [NPORTS-1:0]                 port_reqack;
    logic [NPORTS-1:0][DATA_WIDTH-1:0] port_resp;
    logic [NPORTS-1:0][TAG_WIDTH-1:0]  port_resptag;
    logic [NPORTS-1:0]                 port_respcyc;
    logic [NPORTS-1:0]                 port_respack;

    modport master (
        output port_req, port_reqtag, port_reqcyc, port_respack,
        input  port_reqack, port_resp, port_resptag, port_respcyc
    );

    modport slave (
        input  port_req, port_reqtag, port_reqcyc, port_respack,
        output port_reqack, port_resp, port_resptag, port_respcyc
    );
endinterface

interface sysbus_bus_if
    import sysbus_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH
);
    logic [DATA_WIDTH-1:0] req;
    logic [TAG_WIDTH-1:0]  reqtag;
    logic                  reqcyc;
    logic                  reqack;
    logic [DATA_WIDTH-1:0] resp;
    logic [TAG_WIDTH-1:0]  resptag;
    logic                  respcyc;
    logic                  respack;

    modport master (
        output req, reqtag, reqcyc, respack,
        input  reqack, resp, resptag, respcyc
    );

    modport slave (
        input  req, reqtag, reqcyc, respack,
        output reqack, resp, resptag, respcyc
    );
endinterface

// File: rtl/sysbus_arbiter_rr_arbiter.sv
// Round-robin picker: one-hot grant to the first requester after last_i.
// Pure combinational; the caller registers the winner.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic [N-1:0] gnt_o
);

    always_comb begin
        int  p;
        logic found;
        p     = 0;
        found = 1'b0;
        gnt_o = '0;
        for (int k = 1; k <= N; k++) begin
            p = (int'(last_i) + k) % N;
            if (!found && req_i[p]) begin
                found    = 1'b1;
                gnt_o[p] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sysbus_arbiter.sv
// N-port sysbus arbiter: round-robin packet grant, tag-indexed outstanding
// table, combinational routing of multi-beat read responses to their owner.
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter int NPORTS      = 4,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH   = DEF_TAG_WIDTH,
    parameter int OUTSTANDING = 8,
    parameter int RESP_BEATS  = 8
) (
    input  logic         clk,
    input  logic         reset,
    sysbus_port_if.slave ports,
    sysbus_bus_if.master bus,
    output logic         err_unmatched
);

    localparam int IDX_W = $clog2(NPORTS);
    localparam int ENT_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int WBIT  = TAG_WIDTH - 1;
    localparam logic [ENTRY_BEAT_W-1:0] LAST_BEAT = ENTRY_BEAT_W'(RESP_BEATS - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             first_q, first_d;
    logic             err_q, err_d;
    entry_t           tab_q [OUTSTANDING];
    entry_t           tab_d [OUTSTANDING];

    logic                    full;
    logic [NPORTS-1:0]       elig;
    logic [NPORTS-1:0]       rr_gnt;
    logic [IDX_W-1:0]        rr_idx;
    logic                    alloc;
    logic                    hit;
    logic [ENT_W-1:0]        hit_ent;
    logic [ENTRY_PORT_W-1:0] hit_port;
    logic [ENT_W-1:0]        free_ent;

    // Reads need a slot and a tag not already in flight; writes always may go.
    always_comb begin
        logic dup;
        dup  = 1'b0;
        full = 1'b1;
        elig = '0;
        for (int e = 0; e < OUTSTANDING; e++) begin
            full &= tab_q[e].valid;
        end
        for (int i = 0; i < NPORTS; i++) begin
            dup = 1'b0;
            for (int e = 0; e < OUTSTANDING; e++) begin
                if (tab_q[e].valid &&
                    tab_q[e].tag == ENTRY_TAG_W'(ports.port_reqtag[i])) begin
                    dup = 1'b1;
                end
            end
            elig[i] = ports.port_reqcyc[i] &&
                      (tag_is_write(ENTRY_TAG_W'(ports.port_reqtag[i]), WBIT) ||
                       (!full && !dup));
        end
    end

    rr_arbiter #(
        .N (NPORTS),
        .W (IDX_W)
    ) u_rr (
        .req_i  (elig),
        .last_i (last_q),
        .gnt_o  (rr_gnt)
    );

    always_comb begin
        rr_idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (rr_gnt[i]) rr_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            last_q  <= IDX_W'(NPORTS - 1);
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        gnt_d             = gnt_q;
        last_d            = last_q;
        first_d           = first_q;
        alloc             = 1'b0;
        bus.reqcyc        = 1'b0;
        bus.req           = '0;
        bus.reqtag        = '0;
        ports.port_reqack = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (|rr_gnt) begin
                    state_d = ARB_GRANT;
                    gnt_d   = rr_idx;
                    first_d = 1'b1;
                end
            end
            ARB_GRANT: begin
                bus.reqcyc               = ports.port_reqcyc[gnt_q];
                bus.req                  = DATA_WIDTH'(ports.port_req[gnt_q]);
                bus.reqtag               = ports.port_reqtag[gnt_q];
                ports.port_reqack[gnt_q] = bus.reqack;
                if (!ports.port_reqcyc[gnt_q]) begin
                    state_d = ARB_IDLE;
                    last_d  = gnt_q;
                end else if (bus.reqack) begin
                    first_d = 1'b0;
                    alloc   = first_q && !ports.port_reqtag[gnt_q][WBIT];
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Response CAM; tags are unique among valid entries by construction.
    always_comb begin
        hit      = 1'b0;
        hit_ent  = '0;
        hit_port = '0;
        for (int e = 0; e < OUTSTANDING; e++) begin
            if (!hit && tab_q[e].valid &&
                tab_q[e].tag == ENTRY_TAG_W'(bus.resptag)) begin
                hit      = 1'b1;
                hit_ent  = ENT_W'(e);
                hit_port = tab_q[e].port;
            end
        end
    end

    always_comb begin
        ports.port_respcyc = '0;
        bus.respack        = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            ports.port_resp[i]    = bus.resp;
            ports.port_resptag[i] = bus.resptag;
        end
        if (reset) begin
            if (hit) begin
                ports.port_respcyc[hit_port] = bus.respcyc;
                bus.respack = ports.port_respack[hit_port];
            end else begin
                bus.respack = bus.respcyc;
            end
        end
    end

    // Free slot comes from registered state, so a slot freed this cycle
    // cannot be handed out again until the next one.
    always_comb begin
        logic found;
        found    = 1'b0;
        free_ent = '0;
        for (int e = 0; e < OUTSTANDING; e++) begin
            if (!found && !tab_q[e].valid) begin
                found    = 1'b1;
                free_ent = ENT_W'(e);
            end
        end
    end

    always_comb begin
        tab_d = tab_q;
        err_d = err_q | (bus.respcyc && !hit);
        if (hit && bus.respcyc && bus.respack) begin
            if (tab_q[hit_ent].beats == LAST_BEAT) begin
                tab_d[hit_ent] = '0;
            end else begin
                tab_d[hit_ent].beats = tab_q[hit_ent].beats + 1'b1;
            end
        end
        if (alloc) begin
            tab_d[free_ent].valid = 1'b1;
            tab_d[free_ent].tag   = ENTRY_TAG_W'(ports.port_reqtag[gnt_q]);
            tab_d[free_ent].port  = ENTRY_PORT_W'(gnt_q);
            tab_d[free_ent].beats = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
            for (int e = 0; e < OUTSTANDING; e++) begin
                tab_q[e] <= '0;
            end
        end else begin
            err_q <= err_d;
            tab_q <= tab_d;
        end
    end

    assign err_unmatched = err_q;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter with a tag-keyed reference model
// compared against the DUT every falling edge.
module tb_sysbus_arbiter;
    import sysbus_pkg::*;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int TW = 13;
    localparam int NO = 8;
    localparam int NB = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic err;

    always #5 clk = ~clk;

    sysbus_port_if #(.NPORTS(NP), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) pif ();
    sysbus_bus_if  #(.DATA_WIDTH(DW), .TAG_WIDTH(TW))              bif ();

    sysbus_arbiter #(
        .NPORTS      (NP),
        .DATA_WIDTH  (DW),
        .TAG_WIDTH   (TW),
        .OUTSTANDING (NO),
        .RESP_BEATS  (NB)
    ) dut (
        .clk           (clk),
        .reset         (rst_n),
        .ports         (pif),
        .bus           (bif),
        .err_unmatched (err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: outstanding reads keyed by tag -> owner port / beats consumed.
    bit m_busy, m_first, m_err;
    int m_g, m_last;
    int m_port [int];
    int m_cnt  [int];

    function automatic bit m_elig(int p);
        if (!pif.port_reqcyc[p]) return 1'b0;
        if (pif.port_reqtag[p][TAG_WRITE_BIT]) return 1'b1;
        return (m_port.num() < NO) && !m_port.exists(int'(pif.port_reqtag[p]));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int  rt, p, newtag;
        bit  hit, rdone, do_alloc, found;
        if (!rst_n) begin
            m_busy  = 0;
            m_first = 0;
            m_err   = 0;
            m_g     = 0;
            m_last  = NP - 1;
            m_port.delete();
            m_cnt.delete();
        end else begin
            rt       = int'(bif.resptag);
            hit      = m_port.exists(rt);
            rdone    = bif.respcyc && hit && pif.port_respack[hit ? m_port[rt] : 0];
            do_alloc = 0;
            newtag   = 0;
            found    = 0;
            if (bif.respcyc && !hit) m_err = 1;
            if (!m_busy) begin
                for (int k = 1; k <= NP; k++) begin
                    p = (m_last + k) % NP;
                    if (!found && m_elig(p)) begin
                        found   = 1;
                        m_busy  = 1;
                        m_g     = p;
                        m_first = 1;
                    end
                end
            end else if (!pif.port_reqcyc[m_g]) begin
                m_busy = 0;
                m_last = m_g;
            end else if (bif.reqack) begin
                if (m_first && !pif.port_reqtag[m_g][TAG_WRITE_BIT]) begin
                    do_alloc = 1;
                    newtag   = int'(pif.port_reqtag[m_g]);
                end
                m_first = 0;
            end
            if (rdone) begin
                m_cnt[rt] = m_cnt[rt] + 1;
                if (m_cnt[rt] == NB) begin
                    m_port.delete(rt);
                    m_cnt.delete(rt);
                end
            end
            if (do_alloc) begin
                m_port[newtag] = m_g;
                m_cnt[newtag]  = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [NP-1:0] e_pra, e_prc;
        logic          e_rc, e_ra;
        int            rt;
        if (rst_n) begin
            rt    = int'(bif.resptag);
            e_rc  = m_busy ? pif.port_reqcyc[m_g] : 1'b0;
            e_pra = '0;
            e_prc = '0;
            if (m_busy) e_pra[m_g] = bif.reqack;
            if (m_port.exists(rt)) begin
                e_prc[m_port[rt]] = bif.respcyc;
                e_ra = pif.port_respack[m_port[rt]];
            end else begin
                e_ra = bif.respcyc;
            end
            chk("m_reqcyc", 64'(bif.reqcyc), 64'(e_rc));
            chk("m_port_reqack", 64'(pif.port_reqack), 64'(e_pra));
            chk("m_port_respcyc", 64'(pif.port_respcyc), 64'(e_prc));
            chk("m_respack", 64'(bif.respack), 64'(e_ra));
            chk("m_err", 64'(err), 64'(m_err));
            if (e_rc) begin
                chk("m_req", bif.req, pif.port_req[m_g]);
                chk("m_reqtag", 64'(bif.reqtag), 64'(pif.port_reqtag[m_g]));
            end
            for (int i = 0; i < NP; i++) begin
                chk("m_bcast_resp", pif.port_resp[i], bif.resp);
                chk("m_bcast_tag", 64'(pif.port_resptag[i]), 64'(bif.resptag));
            end
        end
    end

    task automatic raise(int p, logic [TW-1:0] tag);
        pif.port_reqtag[p] = tag;
        pif.port_req[p]    = 64'hA5A5_0000_0000_0000 | (64'(p) << 32) | 64'(tag);
        pif.port_reqcyc[p] = 1'b1;
    endtask

    task automatic drop(int p);
        pif.port_reqcyc[p] = 1'b0;
    endtask

    task automatic wait_grant(int p);
        int t = 0;
        @(negedge clk);
        while (!bif.reqcyc && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("grant_seen", 64'(bif.reqcyc), 64'd1);
        chk("grant_port", 64'(pif.port_reqack), 64'(1 << p));
    endtask

    // Called on a falling edge; returns just after the edge of the last beat.
    task automatic beats(int p, int n);
        int got = 0;
        int t   = 0;
        while (t < 40) begin
            if (bif.reqcyc && pif.port_reqack[p]) got++;
            if (got == n) break;
            @(negedge clk);
            t++;
        end
        chk("req_beats", 64'(got), 64'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic resp(logic [TW-1:0] tag, int n, logic [NP-1:0] mask);
        int got = 0;
        int t   = 0;
        bif.respcyc = 1'b1;
        bif.resptag = tag;
        while (got < n && t < 8 * n + 20) begin
            bif.resp = 64'hD000_0000_0000_0000 | (64'(tag) << 8) | 64'(got);
            @(negedge clk);
            chk("resp_route", 64'(pif.port_respcyc), 64'(mask));
            if (bif.respack) got++;
            @(posedge clk);
            #1;
            t++;
        end
        chk("resp_beats", 64'(got), 64'(n));
    endtask

    task automatic idle_inputs();
        pif.port_req     = '0;
        pif.port_reqtag  = '0;
        pif.port_reqcyc  = '0;
        pif.port_respack = '1;
        bif.reqack       = 1'b1;
        bif.resp         = '0;
        bif.resptag      = '0;
        bif.respcyc      = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle_inputs();
        #2;
        chk("rst_reqcyc", 64'(bif.reqcyc), 64'd0);
        chk("rst_port_reqack", 64'(pif.port_reqack), 64'd0);
        chk("rst_port_respcyc", 64'(pif.port_respcyc), 64'd0);
        chk("rst_respack", 64'(bif.respack), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        do_reset();

        // single read, port 2, tag 0x005; duplicate tag from port 0 held
        raise(2, 13'h005);
        @(negedge clk);
        chk("t1_idle", 64'(bif.reqcyc), 64'd0);
        @(negedge clk);
        chk("t1_grant", 64'(bif.reqcyc), 64'd1);
        chk("t1_tag", 64'(bif.reqtag), 64'h005);
        chk("t1_ack", 64'(pif.port_reqack), 64'b0100);
        @(posedge clk);
        #1;
        drop(2);
        raise(0, 13'h005);
        repeat (3) begin
            @(negedge clk);
            chk("t1_dup_hold", 64'(bif.reqcyc), 64'd0);
        end
        @(posedge clk);
        #1;
        resp(13'h005, NB, 4'b0100);
        bif.respcyc = 1'b0;
        @(negedge clk);
        chk("t1_free_gap", 64'(bif.reqcyc), 64'd0);
        @(negedge clk);
        chk("t1_free_grant", 64'(bif.reqcyc), 64'd1);
        chk("t1_free_port", 64'(pif.port_reqack), 64'b0001);
        @(posedge clk);
        #1;
        drop(0);

        // four simultaneous reads: grants 0,1,2,3 with packet lock
        do_reset();
        for (int p = 0; p < NP; p++) raise(p, 13'(13'h101 + p));
        for (int p = 0; p < NP; p++) begin
            wait_grant(p);
            beats(p, 2);
            drop(p);
        end

        // table full: read held, write passes, read granted after a free
        do_reset();
        for (int i = 0; i < NO; i++) begin
            @(posedge clk);
            #1;
            raise(i % NP, 13'(13'h040 + i));
            wait_grant(i % NP);
            beats(i % NP, 1);
            drop(i % NP);
        end
        raise(1, 13'h050);
        repeat (3) begin
            @(negedge clk);
            chk("t3_full_hold", 64'(bif.reqcyc), 64'd0);
        end
        @(posedge clk);
        #1;
        raise(3, 13'h1003);
        wait_grant(3);
        chk("t3_wr_tag", 64'(bif.reqtag), 64'h1003);
        beats(3, 1);
        drop(3);
        @(negedge clk);
        chk("t3_still_full", 64'(bif.reqcyc), 64'd0);
        @(posedge clk);
        #1;
        resp(13'h040, NB, 4'b0001);
        bif.respcyc = 1'b0;
        @(negedge clk);
        chk("t3_free_gap", 64'(bif.reqcyc), 64'd0);
        @(negedge clk);
        chk("t3_after_free", 64'(bif.reqcyc), 64'd1);
        chk("t3_after_port", 64'(pif.port_reqack), 64'b0010);
        @(posedge clk);
        #1;
        drop(1);

        // out-of-order responses with a 3-cycle stall on port 1
        do_reset();
        raise(0, 13'h011);
        wait_grant(0);
        beats(0, 1);
        drop(0);
        raise(1, 13'h022);
        wait_grant(1);
        beats(1, 1);
        drop(1);
        @(posedge clk);
        #1;
        pif.port_respack[1] = 1'b0;
        bif.respcyc = 1'b1;
        bif.resptag = 13'h022;
        repeat (3) begin
            @(negedge clk);
            chk("t4_stall_ack", 64'(bif.respack), 64'd0);
            chk("t4_stall_route", 64'(pif.port_respcyc), 64'b0010);
        end
        @(posedge clk);
        #1;
        pif.port_respack[1] = 1'b1;
        resp(13'h022, 3, 4'b0010);
        resp(13'h011, NB, 4'b0001);
        resp(13'h022, NB - 3, 4'b0010);
        bif.respcyc = 1'b0;
        @(negedge clk);
        chk("t4_no_err", 64'(err), 64'd0);

        // unmatched tag 0x1FF: absorbed and flagged
        @(posedge clk);
        #1;
        resp(13'h1FF, NB, 4'b0000);
        bif.respcyc = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t5_err_held", 64'(err), 64'd1);
        end

        // reset during beat 4 of a response
        do_reset();
        raise(2, 13'h033);
        wait_grant(2);
        beats(2, 1);
        drop(2);
        @(posedge clk);
        #1;
        resp(13'h033, 3, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_respcyc", 64'(pif.port_respcyc), 64'd0);
        chk("t6_rst_respack", 64'(bif.respack), 64'd0);
        chk("t6_rst_reqcyc", 64'(bif.reqcyc), 64'd0);
        chk("t6_rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        resp(13'h033, NB - 3, 4'b0000);
        bif.respcyc = 1'b0;
        @(negedge clk);
        chk("t6_err", 64'(err), 64'd1);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
